// File: rtl/wb_ddr_wbuf.sv
// Posted-write buffer in front of the wb_ddr slave port: writes are acked on FIFO entry and
// drained in order; reads are forwarded only once the FIFO is empty and the drain FSM is idle.
module wb_ddr_wbuf #(
  parameter int unsigned adr_width  = 32,
  parameter int unsigned dat_width  = 32,
  parameter int unsigned depth_log2 = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_cyc_i,
  input  logic                    s_stb_i,
  input  logic                    s_we_i,
  input  logic [adr_width-1:0]    s_adr_i,
  input  logic [dat_width-1:0]    s_dat_i,
  input  logic [dat_width/8-1:0]  s_sel_i,
  output logic [dat_width-1:0]    s_dat_o,
  output logic                    s_ack_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [adr_width-1:0]    m_adr_o,
  output logic [dat_width-1:0]    m_dat_o,
  output logic [dat_width/8-1:0]  m_sel_o,
  input  logic [dat_width-1:0]    m_dat_i,
  input  logic                    m_ack_i,
  output logic [depth_log2:0]     level,
  output logic                    empty
);

  localparam int unsigned SelWidth = dat_width / 8;
  localparam int unsigned Depth    = 1 << depth_log2;
  localparam logic [depth_log2:0]   LevelFull = (depth_log2 + 1)'(Depth);
  localparam logic [depth_log2:0]   LevelOne  = (depth_log2 + 1)'(1);
  localparam logic [depth_log2-1:0] PtrOne    = depth_log2'(1);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e state_q, state_d;

  logic [adr_width-1:0] adr_mem [Depth];
  logic [dat_width-1:0] dat_mem [Depth];
  logic [SelWidth-1:0]  sel_mem [Depth];

  logic [depth_log2-1:0] wr_ptr_q, rd_ptr_q;
  logic [depth_log2:0]   level_q, level_d;
  logic                  empty_q;
  logic                  s_ack_q, s_ack_d;
  logic [dat_width-1:0]  s_dat_q, s_dat_d;
  logic                  m_cyc_q, m_cyc_d;
  logic                  m_we_q, m_we_d;
  logic [adr_width-1:0]  m_adr_q, m_adr_d;
  logic [dat_width-1:0]  m_dat_q, m_dat_d;
  logic [SelWidth-1:0]   m_sel_q, m_sel_d;

  logic push, pop, rd_req, rd_done;

  // ~s_ack_q keeps the request still on the bus during its ack cycle from being taken twice.
  assign push   = s_cyc_i & s_stb_i & s_we_i & ~s_ack_q & (level_q < LevelFull);
  assign rd_req = s_cyc_i & s_stb_i & ~s_we_i & ~s_ack_q;

  always_comb begin
    state_d = state_q;
    m_cyc_d = m_cyc_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    pop     = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          state_d = StWr;
          m_cyc_d = 1'b1;
          m_we_d  = 1'b1;
          m_adr_d = adr_mem[rd_ptr_q];
          m_dat_d = dat_mem[rd_ptr_q];
          m_sel_d = sel_mem[rd_ptr_q];
        end else if (rd_req) begin
          state_d = StRd;
          m_cyc_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = s_adr_i;
          m_sel_d = s_sel_i;
        end
      end
      StWr: begin
        if (m_ack_i) begin
          pop     = 1'b1;
          m_cyc_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StRd: begin
        if (m_ack_i) begin
          rd_done = 1'b1;
          m_cyc_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        m_cyc_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    s_ack_d = push | rd_done;
    s_dat_d = rd_done ? m_dat_i : s_dat_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      s_ack_q  <= 1'b0;
      s_dat_q  <= '0;
      m_cyc_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_adr_q  <= '0;
      m_dat_q  <= '0;
      m_sel_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      s_ack_q  <= s_ack_d;
      s_dat_q  <= s_dat_d;
      m_cyc_q  <= m_cyc_d;
      m_we_q   <= m_we_d;
      m_adr_q  <= m_adr_d;
      m_dat_q  <= m_dat_d;
      m_sel_q  <= m_sel_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr_q] <= s_adr_i;
      dat_mem[wr_ptr_q] <= s_dat_i;
      sel_mem[wr_ptr_q] <= s_sel_i;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;
  assign level   = level_q;
  assign empty   = empty_q;

endmodule
